// File: rtl/ddr_cmd_pkg.sv
// Shared type codes, FSM state encoding and default widths for the DDR command path.
package ddr_cmd_pkg;

  localparam int unsigned DEF_TYPE_WIDTH = 2;
  localparam int unsigned DEF_ADDR_WIDTH = 27;
  localparam int unsigned DEF_BRST_WIDTH = 6;
  localparam int unsigned DEF_DATA_WIDTH = 128;
  localparam int unsigned DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CMD,
    ST_WDATA,
    ST_WFETCH,
    ST_WWAIT,
    ST_RWAIT
  } state_t;

endpackage

// File: rtl/ddr_cmd_exec.sv
// Replays command-FIFO entries onto the DDR3 controller app interface and
// forwards read beats back to the requester.
module ddr_cmd_exec
  import ddr_cmd_pkg::*;
#(
  parameter int unsigned TYPE_WIDTH = DEF_TYPE_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BRST_WIDTH = DEF_BRST_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH = DEF_MASK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic                  fifo_not_empty,
  input  logic [TYPE_WIDTH-1:0] fifo_cmd_type,
  input  logic [ADDR_WIDTH-1:0] fifo_addr,
  input  logic [BRST_WIDTH-1:0] fifo_burst_cnt,
  input  logic [DATA_WIDTH-1:0] fifo_wt_data,
  input  logic [MASK_WIDTH-1:0] fifo_wt_mask,
  input  logic                  init_calib_complete,
  output logic [2:0]            app_cmd,
  output logic                  app_cmd_en,
  input  logic                  app_cmd_rdy,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [BRST_WIDTH-1:0] app_burst_number,
  output logic [DATA_WIDTH-1:0] app_wdata,
  output logic [MASK_WIDTH-1:0] app_wdata_mask,
  output logic                  app_wdata_en,
  output logic                  app_wdata_end,
  input  logic                  app_wdata_rdy,
  input  logic [DATA_WIDTH-1:0] app_rdata,
  input  logic                  app_rdata_valid,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  err_illegal
);

  state_t                state;
  logic [BRST_WIDTH-1:0] beat_cnt;
  logic                  type_wr;
  logic                  type_rd;

  // Decode of the entry currently presented by the FIFO.
  assign type_wr = (fifo_cmd_type == TYPE_WIDTH'(CMD_WRITE));
  assign type_rd = (fifo_cmd_type == TYPE_WIDTH'(CMD_READ));

  // Every write beat is a full burst beat, so end tracks enable.
  assign app_wdata_end = app_wdata_en;

  // Busy reflects the state register only.
  assign busy = (state != ST_IDLE);

  // Command FSM. fifo_rd_en is registered, so FETCH/WFETCH spend the pop cycle
  // waiting and capture on the following cycle when the FIFO data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      beat_cnt         <= '0;
      fifo_rd_en       <= 1'b0;
      err_illegal      <= 1'b0;
      app_cmd          <= '0;
      app_cmd_en       <= 1'b0;
      app_addr         <= '0;
      app_burst_number <= '0;
      app_wdata        <= '0;
      app_wdata_mask   <= '0;
      app_wdata_en     <= 1'b0;
    end else begin
      fifo_rd_en  <= 1'b0;
      err_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_calib_complete && fifo_not_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!fifo_rd_en) begin
            if (type_wr || type_rd) begin
              app_cmd          <= type_wr ? APP_CMD_WR : APP_CMD_RD;
              app_addr         <= fifo_addr;
              app_burst_number <= fifo_burst_cnt;
              app_wdata        <= fifo_wt_data;
              app_wdata_mask   <= fifo_wt_mask;
              app_cmd_en       <= 1'b1;
              state            <= ST_CMD;
            end else begin
              err_illegal <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_CMD: begin
          if (app_cmd_rdy) begin
            app_cmd_en <= 1'b0;
            beat_cnt   <= app_burst_number;
            if (app_cmd == APP_CMD_WR) begin
              app_wdata_en <= 1'b1;
              state        <= ST_WDATA;
            end else begin
              state <= ST_RWAIT;
            end
          end
        end
        ST_WDATA: begin
          if (app_wdata_rdy) begin
            app_wdata_en <= 1'b0;
            if (beat_cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt - BRST_WIDTH'(1);
              if (fifo_not_empty) begin
                fifo_rd_en <= 1'b1;
                state      <= ST_WFETCH;
              end else begin
                state <= ST_WWAIT;
              end
            end
          end
        end
        ST_WWAIT: begin
          if (fifo_not_empty) begin
            fifo_rd_en <= 1'b1;
            state      <= ST_WFETCH;
          end
        end
        ST_WFETCH: begin
          if (!fifo_rd_en) begin
            app_wdata      <= fifo_wt_data;
            app_wdata_mask <= fifo_wt_mask;
            app_wdata_en   <= 1'b1;
            state          <= ST_WDATA;
          end
        end
        ST_RWAIT: begin
          if (app_rdata_valid) begin
            if (beat_cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt - BRST_WIDTH'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-return register: one-cycle copy of the controller read stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= app_rdata_valid;
      if (app_rdata_valid) begin
        rsp_data <= app_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_exec.sv
// Randomized bench for ddr_cmd_exec with a transaction-level reference model.
module tb_ddr_cmd_exec;

  typedef struct packed {
    logic [1:0]   t;
    logic [26:0]  a;
    logic [5:0]   b;
    logic [127:0] d;
    logic [15:0]  m;
    logic [3:0]   gap;
  } ent_t;

  typedef struct packed {
    logic [2:0]  c;
    logic [26:0] a;
    logic [5:0]  b;
  } cmd_t;

  typedef struct packed {
    logic [15:0]  m;
    logic [127:0] d;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_rd_en;
  logic         fifo_not_empty;
  logic [1:0]   fifo_cmd_type;
  logic [26:0]  fifo_addr;
  logic [5:0]   fifo_burst_cnt;
  logic [127:0] fifo_wt_data;
  logic [15:0]  fifo_wt_mask;
  logic         init_calib_complete;
  logic [2:0]   app_cmd;
  logic         app_cmd_en;
  logic         app_cmd_rdy;
  logic [26:0]  app_addr;
  logic [5:0]   app_burst_number;
  logic [127:0] app_wdata;
  logic [15:0]  app_wdata_mask;
  logic         app_wdata_en;
  logic         app_wdata_end;
  logic         app_wdata_rdy;
  logic [127:0] app_rdata;
  logic         app_rdata_valid;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         busy;
  logic         err_illegal;

  ddr_cmd_exec dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_not_empty      (fifo_not_empty),
    .fifo_cmd_type       (fifo_cmd_type),
    .fifo_addr           (fifo_addr),
    .fifo_burst_cnt      (fifo_burst_cnt),
    .fifo_wt_data        (fifo_wt_data),
    .fifo_wt_mask        (fifo_wt_mask),
    .init_calib_complete (init_calib_complete),
    .app_cmd             (app_cmd),
    .app_cmd_en          (app_cmd_en),
    .app_cmd_rdy         (app_cmd_rdy),
    .app_addr            (app_addr),
    .app_burst_number    (app_burst_number),
    .app_wdata           (app_wdata),
    .app_wdata_mask      (app_wdata_mask),
    .app_wdata_en        (app_wdata_en),
    .app_wdata_end       (app_wdata_end),
    .app_wdata_rdy       (app_wdata_rdy),
    .app_rdata           (app_rdata),
    .app_rdata_valid     (app_rdata_valid),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .busy                (busy),
    .err_illegal         (err_illegal)
  );

  always #5 clk = ~clk;

  // Model state
  ent_t         pend_q[$];
  ent_t         fifo_q[$];
  cmd_t         exp_cmd_q[$];
  beat_t        exp_beat_q[$];
  cmd_t         cmd_log[$];
  logic [127:0] beat_log[$];
  logic [127:0] rsp_log[$];
  logic [127:0] rd_data_q[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           pop_cnt = 0;
  int           err_cnt = 0;
  int           exp_err = 0;
  int           n_entries = 0;
  int           p_cmd = 100;
  int           p_wd = 100;
  bit           stray_en = 1'b0;
  bit           rd_out = 1'b0;
  int           rd_left = 0;
  bit           cmd_stall = 1'b0;
  bit           wd_stall = 1'b0;
  logic [35:0]  st_cmd;
  logic [143:0] st_wd;
  bit           drv_v_last = 1'b0;
  logic [127:0] drv_d_last = '0;
  logic [127:0] rsp_model = '0;
  bit           err_prev = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expand one transaction into FIFO entries plus expected commands/beats.
  task automatic push_txn(input logic [1:0] t, input logic [26:0] a, input logic [5:0] b,
                          input logic [127:0] d0, input logic [15:0] m0,
                          input int gap_idx, input int gap_len, input bit rand_gap);
    ent_t e;
    if (t == 2'b00) begin
      exp_cmd_q.push_back('{3'b000, a, b});
      for (int i = 0; i <= int'(b); i++) begin
        e.t   = (i == 0) ? t : 2'($urandom());
        e.a   = (i == 0) ? a : 27'($urandom());
        e.b   = (i == 0) ? b : 6'($urandom());
        e.d   = d0 + 128'(i);
        e.m   = m0 ^ 16'(i);
        e.gap = (i == gap_idx) ? 4'(gap_len) : (rand_gap ? 4'($urandom_range(0, 3)) : 4'd0);
        exp_beat_q.push_back('{e.m, e.d});
        pend_q.push_back(e);
        n_entries++;
      end
    end else begin
      if (t == 2'b01) exp_cmd_q.push_back('{3'b001, a, b});
      else exp_err++;
      e = '{t, a, b, d0, m0, rand_gap ? 4'($urandom_range(0, 3)) : 4'd0};
      pend_q.push_back(e);
      n_entries++;
    end
  endtask

  // Compare process: checks outputs, plays FIFO and controller, drives inputs at negedge.
  initial begin
    ent_t e;
    cmd_t c;
    beat_t bt;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_q.delete(); fifo_q.delete(); exp_cmd_q.delete(); exp_beat_q.delete();
        rd_out = 1'b0; rd_left = 0; cmd_stall = 1'b0; wd_stall = 1'b0;
        drv_v_last = 1'b0; rsp_model = '0; err_prev = 1'b0;
        app_rdata_valid = 1'b0; app_cmd_rdy = 1'b0; app_wdata_rdy = 1'b0;
        fifo_not_empty = 1'b0;
      end else begin
        // Read-return stream: one-cycle delayed copy, data holds otherwise.
        chk("rsp_valid", 160'(rsp_valid), 160'(drv_v_last));
        if (drv_v_last) rsp_model = drv_d_last;
        chk("rsp_data", 160'(rsp_data), 160'(rsp_model));
        if (rsp_valid) rsp_log.push_back(rsp_data);
        chk("wdata_end", 160'(app_wdata_end), 160'(app_wdata_en));
        if (err_illegal) begin
          err_cnt++;
          chk("err_single_pulse", 160'(err_prev), 160'(0));
        end
        err_prev = err_illegal;
        if (cmd_stall)
          chk("cmd_held", 160'({app_cmd_en, app_cmd, app_addr, app_burst_number}), 160'({1'b1, st_cmd}));
        if (wd_stall)
          chk("wdata_held", 160'({app_wdata_en, app_wdata_mask, app_wdata}), 160'({1'b1, st_wd}));
        if (app_cmd_en || app_wdata_en || rd_out) chk("busy", 160'(busy), 160'(1));
        // FIFO pop
        if (fifo_rd_en) begin
          chk("pop_nonempty", 160'(fifo_not_empty), 160'(1));
          chk("pop_in_read", 160'(rd_out), 160'(0));
          pop_cnt++;
          if (fifo_q.size() != 0) begin
            e = fifo_q.pop_front();
            fifo_cmd_type = e.t; fifo_addr = e.a; fifo_burst_cnt = e.b;
            fifo_wt_data = e.d;  fifo_wt_mask = e.m;
          end
        end
        // Release of pending entries into the FIFO (gap counts empty cycles)
        if (pend_q.size() != 0) begin
          e = pend_q[0];
          if (e.gap == 4'd0) begin
            fifo_q.push_back(e);
            void'(pend_q.pop_front());
          end else if (fifo_q.size() == 0) begin
            e.gap = e.gap - 4'd1;
            pend_q[0] = e;
          end
        end
        fifo_not_empty = (fifo_q.size() != 0);
        // Read beats for next edge
        app_rdata = rand128();
        app_rdata_valid = 1'b0;
        if (rd_out) begin
          if ($urandom_range(0, 1) == 1) begin
            app_rdata_valid = 1'b1;
            if (rd_data_q.size() != 0) app_rdata = rd_data_q.pop_front();
            rd_left--;
            if (rd_left == 0) rd_out = 1'b0;
          end
        end else if (stray_en && $urandom_range(0, 19) == 0) begin
          app_rdata_valid = 1'b1;
        end
        drv_v_last = app_rdata_valid;
        drv_d_last = app_rdata;
        // Ready choice and the handshakes that will complete at the next edge
        app_cmd_rdy   = ($urandom_range(0, 99) < p_cmd);
        app_wdata_rdy = ($urandom_range(0, 99) < p_wd);
        cmd_stall = app_cmd_en && !app_cmd_rdy;
        st_cmd    = {app_cmd, app_addr, app_burst_number};
        wd_stall  = app_wdata_en && !app_wdata_rdy;
        st_wd     = {app_wdata_mask, app_wdata};
        if (app_cmd_en && app_cmd_rdy) begin
          cmd_log.push_back('{app_cmd, app_addr, app_burst_number});
          chk("cmd_expected", 160'(exp_cmd_q.size() != 0), 160'(1));
          if (exp_cmd_q.size() != 0) begin
            c = exp_cmd_q.pop_front();
            chk("cmd", 160'({app_cmd, app_addr, app_burst_number}), 160'(c));
            if (c.c == 3'b001) begin
              rd_out  = 1'b1;
              rd_left = int'(c.b) + 1;
            end
          end
        end
        if (app_wdata_en && app_wdata_rdy) begin
          beat_log.push_back(app_wdata);
          chk("beat_expected", 160'(exp_beat_q.size() != 0), 160'(1));
          if (exp_beat_q.size() != 0) begin
            bt = exp_beat_q.pop_front();
            chk("wbeat", 160'({app_wdata_mask, app_wdata}), 160'(bt));
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget, input bit tog);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (tog) init_calib_complete = ($urandom_range(0, 7) != 0);
      done = (pend_q.size() == 0) && (fifo_q.size() == 0) && (exp_cmd_q.size() == 0) &&
             (exp_beat_q.size() == 0) && !rd_out && !busy && !fifo_rd_en;
    end
    init_calib_complete = 1'b1;
    chk("drain", 160'(done), 160'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sig(input string name, input int budget, input bit which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = which ? app_wdata_en : app_cmd_en;
    end
    chk(name, 160'(seen), 160'(1));
  endtask

  initial begin
    int p0, c0, b0, r0, e0;
    rst = 1'b1;
    init_calib_complete = 1'b0;
    app_cmd_rdy = 1'b0; app_wdata_rdy = 1'b0;
    app_rdata = '0; app_rdata_valid = 1'b0;
    fifo_not_empty = 1'b0;
    fifo_cmd_type = '0; fifo_addr = '0; fifo_burst_cnt = '0; fifo_wt_data = '0; fifo_wt_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 160'({fifo_rd_en, app_cmd_en, app_wdata_en, app_wdata_end, rsp_valid, busy, err_illegal, app_cmd}), 160'(0));
    chk("reset_data", 160'({app_addr, app_burst_number, app_wdata_mask}), 160'(0));
    chk("reset_wdata", 160'(app_wdata), 160'(0));
    chk("reset_rsp", 160'(rsp_data), 160'(0));
    rst = 1'b0;
    init_calib_complete = 1'b1;

    // Single write
    p0 = pop_cnt; c0 = cmd_log.size(); b0 = beat_log.size();
    push_txn(2'b00, 27'h0000100, 6'd0, {16{8'hA5}}, 16'h0, -1, 0, 1'b0);
    wait_drain(300, 1'b0);
    chk("t1_pops", 160'(pop_cnt - p0), 160'(1));
    chk("t1_ncmd", 160'(cmd_log.size() - c0), 160'(1));
    chk("t1_cmd", 160'(cmd_log[cmd_log.size()-1]), 160'({3'b000, 27'h0000100, 6'd0}));
    chk("t1_nbeat", 160'(beat_log.size() - b0), 160'(1));
    chk("t1_beat", 160'(beat_log[beat_log.size()-1]), 160'({16{8'hA5}}));

    // Burst write with FIFO starved after the second entry
    p0 = pop_cnt; c0 = cmd_log.size(); b0 = beat_log.size();
    push_txn(2'b00, 27'h0000040, 6'd3, 128'd1, 16'h0, 2, 5, 1'b0);
    wait_drain(300, 1'b0);
    chk("t2_pops", 160'(pop_cnt - p0), 160'(4));
    chk("t2_ncmd", 160'(cmd_log.size() - c0), 160'(1));
    chk("t2_nbeat", 160'(beat_log.size() - b0), 160'(4));
    for (int i = 0; i < 4; i++)
      if (b0 + i < beat_log.size()) chk("t2_beat", 160'(beat_log[b0+i]), 160'(i + 1));

    // Read burst of two beats
    p0 = pop_cnt; r0 = rsp_log.size();
    rd_data_q.push_back(128'h11);
    rd_data_q.push_back(128'h22);
    push_txn(2'b01, 27'h0000200, 6'd1, '0, '0, -1, 0, 1'b0);
    wait_drain(300, 1'b0);
    chk("t3_pops", 160'(pop_cnt - p0), 160'(1));
    chk("t3_cmd", 160'(cmd_log[cmd_log.size()-1]), 160'({3'b001, 27'h0000200, 6'd1}));
    chk("t3_nrsp", 160'(rsp_log.size() - r0), 160'(2));
    if (rsp_log.size() >= r0 + 2) begin
      chk("t3_rsp0", 160'(rsp_log[r0]), 160'(128'h11));
      chk("t3_rsp1", 160'(rsp_log[r0+1]), 160'(128'h22));
    end

    // Backpressure on command then data
    c0 = cmd_log.size(); b0 = beat_log.size();
    p_cmd = 0;
    push_txn(2'b00, 27'h0ABCDEF, 6'd1, 128'hDEAD_BEEF_0000, 16'h00F0, -1, 0, 1'b0);
    wait_sig("t4_cmd_en", 100, 1'b0);
    repeat (4) @(negedge clk);
    p_wd = 0; p_cmd = 100;
    wait_sig("t4_wdata_en", 100, 1'b1);
    repeat (3) @(negedge clk);
    p_wd = 100;
    wait_drain(300, 1'b0);
    chk("t4_ncmd", 160'(cmd_log.size() - c0), 160'(1));
    chk("t4_nbeat", 160'(beat_log.size() - b0), 160'(2));

    // Illegal entry followed by a read
    c0 = cmd_log.size(); e0 = err_cnt;
    push_txn(2'b11, 27'h0000300, 6'd0, rand128(), 16'h0, -1, 0, 1'b0);
    push_txn(2'b01, 27'h0000400, 6'd0, '0, '0, -1, 0, 1'b0);
    wait_drain(300, 1'b0);
    chk("t5_err", 160'(err_cnt - e0), 160'(1));
    chk("t5_ncmd", 160'(cmd_log.size() - c0), 160'(1));
    chk("t5_cmd", 160'(cmd_log[cmd_log.size()-1]), 160'({3'b001, 27'h0000400, 6'd0}));

    // No pop while uncalibrated
    p0 = pop_cnt;
    init_calib_complete = 1'b0;
    push_txn(2'b00, 27'h0000500, 6'd0, 128'h55, 16'h0, -1, 0, 1'b0);
    repeat (20) @(negedge clk);
    chk("t6_no_pop", 160'(pop_cnt - p0), 160'(0));
    chk("t6_idle", 160'(busy), 160'(0));
    init_calib_complete = 1'b1;
    wait_drain(300, 1'b0);
    chk("t6_pops", 160'(pop_cnt - p0), 160'(1));

    // Randomized traffic
    stray_en = 1'b1; p_cmd = 60; p_wd = 60;
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [1:0] t;
      r = $urandom_range(0, 9);
      t = (r < 1) ? 2'($urandom_range(2, 3)) : ((r < 5) ? 2'b01 : 2'b00);
      push_txn(t, 27'($urandom()), 6'($urandom_range(0, 7)), rand128(), 16'($urandom()), -1, 0, 1'b1);
    end
    wait_drain(20000, 1'b1);
    stray_en = 1'b0; p_cmd = 100; p_wd = 100;
    chk("total_pops", 160'(pop_cnt), 160'(n_entries));
    chk("total_err", 160'(err_cnt), 160'(exp_err));

    // Reset in the middle of a write beat
    p_wd = 0;
    push_txn(2'b00, 27'h1234567, 6'd2, {1'b1, 127'h77}, 16'hFFFF, -1, 0, 1'b0);
    wait_sig("t8_wdata_en", 100, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_ctrl", 160'({fifo_rd_en, app_cmd_en, app_wdata_en, app_wdata_end, rsp_valid, busy, err_illegal, app_cmd}), 160'(0));
    chk("t8_rst_data", 160'({app_addr, app_burst_number, app_wdata_mask}), 160'(0));
    chk("t8_rst_wdata", 160'(app_wdata), 160'(0));
    chk("t8_rst_rsp", 160'(rsp_data), 160'(0));
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    p_wd = 100;
    c0 = cmd_log.size();
    push_txn(2'b01, 27'h0000600, 6'd0, '0, '0, -1, 0, 1'b0);
    wait_drain(300, 1'b0);
    chk("t8_recover_cmd", 160'(cmd_log[cmd_log.size()-1]), 160'({3'b001, 27'h0000600, 6'd0}));
    chk("t8_recover_n", 160'(cmd_log.size() - c0), 160'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
